// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : instruction_fetch_pkg
//  Purpose  : Shared types and constants for the instruction fetch stage.
//  Revision : 1.0  initial release
// ============================================================================
package instruction_fetch_pkg;

  localparam int          INSTR_WORD_BYTES = 4;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  // One buffered fetch result handed to decode
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : instruction_fetch_if
//  Purpose  : Memory request/response, redirect and decode handshake bundle
//             of the instruction fetch stage.
//  Revision : 1.0  initial release
// ============================================================================
interface instruction_fetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  // Fetch stage side
  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

  // Memory / decode / execute side
  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

endinterface
`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Synchronous FIFO of fetch entries. Flush wins over push/pop;
//             push while full is accepted only together with a pop.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue
  import instruction_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         push,
  input  wire fetch_entry_t push_data,
  input  wire logic         pop,
  input  wire logic         flush,
  output fetch_entry_t      head,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (r_count == '0);
  assign full   = (r_count == CNT_W'(DEPTH));
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : Front-end fetch stage. Owns the PC, issues word fetches under a
//             credit limit, buffers in-order responses and hands {instr, pc}
//             to decode. Redirects flush the queue and discard stale
//             in-flight responses.
//  Options  : FETCH_MISALIGN_CHECK_EN adds the fetch_misaligned output and
//             stalls fetch after a redirect to a non word-aligned target.
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  instruction_fetch_if.master bus
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                fetch_misaligned
`endif
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_resp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop;

  logic [CNT_W-1:0] w_q_count;
  logic             w_q_empty;
  logic             w_q_full;
  logic             w_q_pop;
  fetch_entry_t     w_q_head;
  fetch_entry_t     w_push_data;

  logic [SUM_W-1:0] w_in_flight;
  logic             w_credit_ok;
  logic             w_hold;
  logic             w_req_fire;
  logic             w_rsp_legal;
  logic             w_rsp_use_drop;
  logic             w_rsp_keep;
  logic [31:0]      w_redirect_target;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misaligned;

  // Sticky misalignment flag, re-evaluated on every redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misaligned <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_misaligned <= (bus.redirect_pc[1:0] != 2'b00);
    end
  end

  assign fetch_misaligned  = r_misaligned;
  assign w_hold            = r_misaligned;
  assign w_redirect_target = bus.redirect_pc;
`else
  assign w_hold            = 1'b0;
  assign w_redirect_target = bus.redirect_pc & ~32'(INSTR_WORD_BYTES - 1);
`endif

  // Every accepted request owns a slot until its entry leaves the queue
  assign w_in_flight = SUM_W'(r_outstanding) + SUM_W'(r_drop) + SUM_W'(w_q_count);
  assign w_credit_ok = (w_in_flight < SUM_W'(QUEUE_DEPTH));

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && w_credit_ok && !w_hold;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign w_req_fire         = bus.imem_req_valid && bus.imem_req_ready;

  // Responses with nothing in flight are ignored; stale ones burn a drop credit
  assign w_rsp_legal    = bus.imem_rsp_valid && ((r_outstanding != '0) || (r_drop != '0));
  assign w_rsp_use_drop = w_rsp_legal && (r_drop != '0);
  assign w_rsp_keep     = w_rsp_legal && (r_drop == '0) && !bus.redirect_valid;

  assign w_push_data = '{instr: bus.imem_rsp_data, pc: r_resp_pc};
  assign w_q_pop     = !w_q_empty && bus.id_ready;

  // PC tracking and outstanding/drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc    <= w_redirect_target;
      r_resp_pc     <= w_redirect_target;
      r_outstanding <= '0;
      r_drop        <= r_drop + r_outstanding - CNT_W'(w_rsp_legal);
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'(INSTR_WORD_BYTES);
      end
      if (w_rsp_keep) begin
        r_resp_pc <= r_resp_pc + 32'(INSTR_WORD_BYTES);
      end
      r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_keep);
      if (w_rsp_use_drop) begin
        r_drop <= r_drop - CNT_W'(1);
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (w_rsp_keep),
    .push_data (w_push_data),
    .pop       (w_q_pop),
    .flush     (bus.redirect_valid),
    .head      (w_q_head),
    .count     (w_q_count),
    .empty     (w_q_empty),
    .full      (w_q_full)
  );

  assign bus.id_valid = !w_q_empty;
  assign bus.id_instr = w_q_head.instr;
  assign bus.id_pc    = w_q_head.pc;

`ifndef SYNTHESIS
  // Protocol and credit sanity checks
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!bus.imem_rsp_valid || w_rsp_legal)
        else $error("instruction_fetch: response with no request in flight");
      assert (!(w_rsp_keep && w_q_full && !w_q_pop))
        else $error("instruction_fetch: queue overflow");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_instruction_fetch
//  Purpose  : Randomized self-checking bench for instruction_fetch. A memory
//             model returns in-order responses; an epoch-tagged queue model
//             predicts what decode must see.
//  Options  : FETCH_MISALIGN_CHECK_EN also checks fetch_misaligned.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          QUEUE_DEPTH = 2;

  logic clk = 1'b0;
  logic rst;

  // 10 ns clock
  always #5 clk = ~clk;

  instruction_fetch_if bus ();
`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;
`endif

  instruction_fetch #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned (misaligned)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t        memq[$];
  fetch_entry_t modelq[$];
  int           epoch;
  int           cyc;
  logic [31:0]  exp_fetch;
  bit           mis_model;
  int           checks;
  int           failures;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 4))
      0:       t = 32'h0000_0100;
      1:       t = 32'h0000_0200;
      2:       t = 32'hFFFF_FFF8;
      3:       t = 32'h0000_0102;
      default: t = $urandom & 32'h0000_FFFC;
    endcase
    return t;
  endfunction

  // One clock cycle: drive at negedge, check, then advance the model at posedge
  task automatic step(input int p_ready, input int p_rsp, input int p_idr, input int p_redir,
                      input int max_lat, input bit force_redir, input logic [31:0] force_tgt);
    bit           rsp;
    bit           redir;
    bit           fire;
    bit           pop;
    bit           exp_req;
    logic [31:0]  tgt;
    mreq_t        r;
    fetch_entry_t e;
    @(negedge clk);
    rsp = (memq.size() > 0) && (memq[0].due <= cyc) && ($urandom_range(0, 99) < p_rsp);
    redir = force_redir || ($urandom_range(0, 99) < p_redir);
    tgt   = force_redir ? force_tgt : pick_target();
    bus.imem_req_ready = ($urandom_range(0, 99) < p_ready);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(memq[0].addr) : $urandom;
    bus.id_ready       = ($urandom_range(0, 99) < p_idr);
    bus.redirect_valid = redir;
    bus.redirect_pc    = redir ? tgt : $urandom;
    #1;
    exp_req = !redir && (memq.size() + modelq.size() < QUEUE_DEPTH) && !mis_model;
    check_val("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
    if (bus.imem_req_valid) check_val("req_addr", bus.imem_req_addr, exp_fetch);
    check_val("id_valid", 32'(bus.id_valid), 32'(modelq.size() != 0));
    if (modelq.size() != 0) begin
      check_val("id_pc", bus.id_pc, modelq[0].pc);
      check_val("id_instr", bus.id_instr, modelq[0].instr);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    check_val("misaligned", 32'(misaligned), 32'(mis_model));
`endif
    fire = bus.imem_req_valid && bus.imem_req_ready && !redir;
    pop  = (modelq.size() != 0) && bus.id_ready;
    @(posedge clk);
    cyc++;
    if (pop && !redir) void'(modelq.pop_front());
    if (rsp) begin
      r = memq.pop_front();
      if (!redir && r.epoch == epoch) begin
        e.instr = mem_word(r.addr);
        e.pc    = r.addr;
        modelq.push_back(e);
      end
    end
    if (redir) begin
      modelq.delete();
      epoch++;
`ifdef FETCH_MISALIGN_CHECK_EN
      exp_fetch = tgt;
      mis_model = (tgt[1:0] != 2'b00);
`else
      exp_fetch = tgt & 32'hFFFF_FFFC;
`endif
    end
    if (fire) begin
      r.addr  = exp_fetch;
      r.epoch = epoch;
      r.due   = cyc + $urandom_range(0, max_lat - 1);
      memq.push_back(r);
      exp_fetch = exp_fetch + 32'd4;
    end
  endtask

  task automatic run(input int n, input int p_ready, input int p_rsp, input int p_idr,
                     input int p_redir, input int max_lat);
    for (int k = 0; k < n; k++) step(p_ready, p_rsp, p_idr, p_redir, max_lat, 1'b0, 32'h0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    epoch     = 0;
    cyc       = 0;
    mis_model = 1'b0;
    exp_fetch = RESET_PC;
    rst                = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Reset state, including a redirect that reset must override
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.redirect_valid = (k == 2);
      bus.redirect_pc    = 32'h0000_0500;
      #1;
      check_val("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
      if (k > 0) begin
        check_val("rst_id_valid", 32'(bus.id_valid), 32'h0);
        check_val("rst_id_instr", bus.id_instr, 32'h0);
        check_val("rst_id_pc", bus.id_pc, 32'h0);
      end
    end
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    rst                = 1'b0;

    // Streaming with 1-cycle memory and decode always ready
    run(30, 100, 100, 100, 0, 1);
    // Decode stall: credit must cap issue
    run(10, 100, 100, 0, 0, 1);
    run(6, 100, 100, 100, 0, 1);
    // Two requests in flight, then redirect to 0x100
    run(3, 100, 0, 100, 0, 1);
    step(100, 0, 100, 0, 1, 1'b1, 32'h0000_0100);
    run(12, 100, 100, 100, 0, 1);
    // Redirect coinciding with a response, then back-to-back redirect to 0x200
    run(2, 100, 0, 100, 0, 1);
    step(100, 100, 100, 0, 1, 1'b1, 32'h0000_0180);
    step(100, 100, 100, 0, 1, 1'b1, 32'h0000_0200);
    run(12, 100, 100, 100, 0, 1);
    // Address wrap at the top of memory
    step(100, 100, 100, 0, 1, 1'b1, 32'hFFFF_FFFC);
    run(10, 100, 100, 100, 0, 1);
    // Misaligned redirect target, then an aligned one
    step(100, 100, 100, 0, 1, 1'b1, 32'h0000_0102);
    run(4, 100, 100, 100, 0, 1);
    step(100, 100, 100, 0, 1, 1'b1, 32'h0000_0104);
    run(10, 100, 100, 100, 0, 1);
    // Randomized traffic with variable latency and redirects
    run(2000, 70, 60, 70, 4, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Front-end stage directly upstream of instruction_decode. Owns the PC, issues word fetches to instruction memory over a valid/ready request channel, and accepts in-order responses. Buffers fetched words in a small queue and presents {instr, pc} to decode with a valid/ready handshake. Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC of first fetch after reset; must be 4-byte aligned.
QUEUE_DEPTH, 2, number of instruction queue entries, and also the maximum of outstanding requests plus queued entries; range 1..8.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts the request this cycle
imem_req_addr  output  32  word address of the request; equals fetch_pc
imem_rsp_valid  input  1  response valid; responses arrive in order, one per accepted request, at least 1 cycle after acceptance
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  taken branch or jump from decode/execute
redirect_pc  input  32  redirect target
id_valid  output  1  decode-side entry valid
id_ready  input  1  decode consumes the head entry
id_instr  output  32  head instruction
id_pc  output  32  PC of head instruction
fetch_misaligned  output  1  only present with FETCH_MISALIGN_CHECK_EN

Behaviour:
- State: fetch_pc (next request address), resp_pc (PC of the next kept response), outstanding count, drop count, and queue.
- Reset values: fetch_pc = resp_pc = RESET_PC; all counts = 0; queue empty; id_valid = 0; id_instr = 0; id_pc = 0; imem_req_valid forced to 0 while rst is high. rst overrides redirect and every other input.
- Issue rule: imem_req_valid = !rst && !redirect_valid && (outstanding + drop + queue_count < QUEUE_DEPTH).
- On request accept (valid && ready): outstanding is incremented and fetch_pc <= fetch_pc + 4. The add is modulo 2^32 and wraps from 32'hFFFF_FFFC to 0.
- imem_req_addr must stay stable while valid is high and not yet accepted, except in a redirect cycle, where valid drops.
- Kept response (rsp_valid && drop == 0): {imem_rsp_data, resp_pc} is pushed into the queue, resp_pc += 4, and outstanding is decremented.
- Dropped response (rsp_valid && drop > 0): data is discarded and drop is decremented.
- A response with outstanding + drop == 0 is a protocol violation. A simulation assertion must flag it, and the RTL ignores it.
- Output: id_valid = queue not empty, and id_instr/id_pc = head. The entry is popped on id_valid && id_ready.
- Latency: a response in cycle N appears on id_valid in cycle N+1. After reset deassertion, the first request is raised in the first cycle.
- Push and pop in the same cycle are legal at any occupancy. The credit rule guarantees no overflow, and a simulation assertion checks this.
- Redirect (redirect_valid in cycle N):
  - queue flushed; id_valid = 0 in N+1;
  - fetch_pc <= resp_pc <= redirect_pc;
  - drop <= drop + outstanding - (rsp_valid in N ? 1 : 0);
  - outstanding <= 0;
  - any response in cycle N is dropped;
  - the first request to the new target is raised in N+1, subject to credit.
- Back-to-back redirects: the last one wins, and the drop accounting accumulates.
- A redirect while id_valid && id_ready in the same cycle: the pop is irrelevant because the flush wins.
- Decode stalled (id_ready = 0) with the queue full: no requests are issued, the PC holds, and no data is lost.

Optional Feature:
- FETCH_MISALIGN_CHECK_EN defined:
  - fetch_misaligned is a registered output. It is set in N+1 when redirect_pc[1:0] != 0 in cycle N.
  - It is cleared by the next redirect with an aligned target, or by rst.
  - While it is set, imem_req_valid is held at 0.
  - redirect_pc is still loaded into fetch_pc and resp_pc, so the misaligned target is not truncated.
- Not defined: the port is absent. redirect_pc[1:0] is ignored and treated as 0.

Decomposition:
- Package common gets:
  - fetch_entry_t (packed struct {instr[31:0], pc[31:0]});
  - INSTR_WORD_BYTES = 4;
  - INSTR_NOP = 32'h0000_0013.
- Sub-module fetch_queue: a synchronous FIFO of fetch_entry_t with DEPTH, push, pop, flush (flush wins over push/pop), count, empty and full, and reset to empty.

Test Plan:
- Reset then imem_req_ready = 1 with 1-cycle response latency and id_ready = 1 -> addresses 0x0, 0x4, 0x8… are issued back-to-back, and id_pc tracks them with id_instr equal to the returned data.
- id_ready = 0 for 10 cycles -> at most 2 requests are issued, the queue holds 2 entries, and imem_req_valid stays 0 until a pop.
- 2 requests in flight and redirect to 0x100 -> both stale responses are dropped, and the next id_pc = 0x100 with its data.
- Redirect in the same cycle as a response, then a second redirect to 0x200 on the next cycle -> no stale entry reaches decode, and the first id_pc = 0x200.
- redirect_pc = 0xFFFF_FFFC -> the fetch sequence is 0xFFFF_FFFC then 0x0.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> fetch_misaligned = 1 next cycle with no requests; a later redirect to 0x104 clears it and fetch resumes.
